lsu_mem_master: RTL and testbench

//  Load/store initiator that drives the word-addressable byte-lane data memory on behalf of the CPU datapath.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/lsu_mem_master_if.sv | 29 ++
 rtl/lsu_mem_master_lane_align.sv | 36 +++
 rtl/lsu_mem_master.sv | 109 ++++++++++
 tb/tb_lsu_mem_master.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the LSU data-memory master: access sizes, FSM states, byte lanes, captured request.
package mem_pkg;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_t;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

  // Lane 0 is the most significant byte (big-endian lane order).
  typedef logic [0:NUM_LANES-1][7:0] byte_lanes_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response port from EX/MEM plus the data-memory port of the LSU master.
interface lsu_mem_master_if;
  import mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  byte_lanes_t mem_wdata;
  byte_lanes_t mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational byte-lane steering: load extraction/extension and sub-word store merge.
module lane_align
  import mem_pkg::*;
(
  input  byte_lanes_t rdata,
  input  byte_lanes_t old_lanes,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] ext,
  output byte_lanes_t merged
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = rdata[offset];
    h   = offset[1] ? {rdata[2], rdata[3]} : {rdata[0], rdata[1]};
    ext = rdata;
    case (size)
      SZ_B:    ext = {{24{sgn & b[7]}}, b};
      SZ_H:    ext = {{16{sgn & h[15]}}, h};
      default: ext = rdata;
    endcase
  end

  // Unselected lanes keep what was read during RD.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    assign merged[i] = (size == SZ_W)                        ? wdata[31-8*i -: 8] :
                       (size == SZ_B && offset == LI)        ? wdata[7:0] :
                       (size == SZ_H && offset[1] == LI[1])  ? (LI[0] ? wdata[7:0] : wdata[15:8]) :
                                                               old_lanes[i];
  end
endmodule

// File: rtl/lsu_mem_master.sv
// LSU master: turns byte/half/word loads and stores into word-aligned accesses, RMW for sub-word stores.
module lsu_mem_master
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ADDR_LO     = 32'd0,
  parameter logic [31:0] ADDR_HI     = 32'd65535
)(
  input  logic              clk,
  input  logic              rst_b,
  lsu_mem_master_if.master  bus
);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  lsu_state_t  state, state_nxt;
  lsu_req_t    req_q;
  logic [CW-1:0] cnt;
  byte_lanes_t rd_q, merged;
  logic [31:0] ext, rdata_q;
  logic        err_q;
  logic        acc, acc_err;
  logic [32:0] last_b;

  // Priority: illegal size, then alignment, then range of every byte touched.
  always_comb begin
    last_b  = {1'b0, bus.req_addr} + 33'(size_bytes(bus.req_size)) - 33'd1;
    acc_err = 1'b0;
    if (bus.req_size == 2'b11)                                  acc_err = 1'b1;
    else if (bus.req_size == SZ_H && bus.req_addr[0])           acc_err = 1'b1;
    else if (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00) acc_err = 1'b1;
    else if (bus.req_addr < ADDR_LO || last_b > {1'b0, ADDR_HI}) acc_err = 1'b1;
  end

  assign acc = bus.req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid)
              state_nxt = acc_err ? RESP :
                          (bus.req_we && bus.req_size == SZ_W) ? WR : RD;
      RD:   if (cnt == '0) state_nxt = req_q.we ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.mem_we     = (state == WR);
    bus.mem_wdata  = (state == WR) ? merged : '0;
  end

  assign bus.mem_addr   = {req_q.addr[31:2], 2'b00};
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      req_q   <= '0;
      cnt     <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (acc) begin
        req_q <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                   addr: bus.req_addr, wdata: bus.req_wdata};
        cnt   <= CW'(WAIT_CYCLES);
        if (acc_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == RD) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          rd_q <= bus.mem_rdata;
          if (!req_q.we) begin
            rdata_q <= ext;
            err_q   <= 1'b0;
          end
        end
      end
      if (state == WR) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  lane_align u_align (
    .rdata     (bus.mem_rdata),
    .old_lanes (rd_q),
    .offset    (req_q.addr[1:0]),
    .size      (req_q.size),
    .sgn       (req_q.sgn),
    .wdata     (req_q.wdata),
    .ext       (ext),
    .merged    (merged)
  );
endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: one DUT with no wait states, one with three.
module tb_lsu_mem_master;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_master_if bus0();
  lsu_mem_master_if bus3();

  logic        rv0 = 1'b0, rv3 = 1'b0;
  logic        t_we = 1'b0, t_sg = 1'b0;
  logic [1:0]  t_size = 2'b00;
  logic [31:0] t_addr = '0, t_wdata = '0;

  assign bus0.req_valid = rv0;  assign bus3.req_valid = rv3;
  assign bus0.req_we = t_we;    assign bus3.req_we = t_we;
  assign bus0.req_size = t_size; assign bus3.req_size = t_size;
  assign bus0.req_signed = t_sg; assign bus3.req_signed = t_sg;
  assign bus0.req_addr = t_addr; assign bus3.req_addr = t_addr;
  assign bus0.req_wdata = t_wdata; assign bus3.req_wdata = t_wdata;

  lsu_mem_master #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_b(rst_b), .bus(bus0.master));
  lsu_mem_master #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_b(rst_b), .bus(bus3.master));

  // Memory models: byte arrays indexed by the low address byte.
  logic [7:0]  mem0 [0:255];
  logic [7:0]  mem3 [0:255];
  logic        pre_we = 1'b0;
  int          pre_sel = 0;
  logic [7:0]  pre_a = '0;
  logic [31:0] pre_w = '0;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus0.mem_rdata[k] = mem0[8'(bus0.mem_addr[7:0] + 8'(k))];
      bus3.mem_rdata[k] = mem3[8'(bus3.mem_addr[7:0] + 8'(k))];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (pre_we && pre_sel == 0) mem0[8'(pre_a + 8'(k))] <= pre_w[31-8*k -: 8];
      if (pre_we && pre_sel != 0) mem3[8'(pre_a + 8'(k))] <= pre_w[31-8*k -: 8];
      if (bus0.mem_we) mem0[8'(bus0.mem_addr[7:0] + 8'(k))] <= bus0.mem_wdata[k];
      if (bus3.mem_we) mem3[8'(bus3.mem_addr[7:0] + 8'(k))] <= bus3.mem_wdata[k];
    end
  end

  int rv0_cnt = 0, we0_cnt = 0, we3_cnt = 0, we3_last = 0;
  always @(negedge clk) begin
    if (bus0.resp_valid) rv0_cnt <= rv0_cnt + 1;
    if (bus0.mem_we)     we0_cnt <= we0_cnt + 1;
    if (bus3.mem_we) begin
      we3_cnt  <= we3_cnt + 1;
      we3_last <= cyc;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  int chk = 0, pass_n = 0;

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.req_ready : bus3.req_ready;
  endfunction
  function automatic logic rvld(input int d);
    return (d == 0) ? bus0.resp_valid : bus3.resp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? bus0.resp_rdata : bus3.resp_rdata;
  endfunction
  function automatic logic rerr(input int d);
    return (d == 0) ? bus0.resp_err : bus3.resp_err;
  endfunction
  function automatic logic [31:0] rd_word(input int d, input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[31-8*k -: 8] = (d == 0) ? mem0[8'(a + k)] : mem3[8'(a + k)];
    return w;
  endfunction

  task automatic pre_word(input int d, input int a, input logic [31:0] w);
    @(negedge clk);
    pre_sel = d; pre_a = 8'(a); pre_w = w; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request; the expectation goes in the scoreboard and is popped when the response appears.
  task automatic xact(input int d, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat,
                      input string nm, output int n, output int r);
    exp_t e;
    bit got, rdy_hi;
    for (int i = 0; i < 20 && !rdy(d); i++) @(negedge clk);
    t_we = we; t_size = sz; t_sg = sg; t_addr = a; t_wdata = wd;
    if (d == 0) rv0 = 1'b1; else rv3 = 1'b1;
    sbq.push_back('{exp_rd, exp_err, lat, nm});
    @(posedge clk);
    @(negedge clk);
    n = cyc;
    rv0 = 1'b0; rv3 = 1'b0;
    t_size = 2'b11; t_addr = 32'hFFFF_FFFF; t_wdata = $urandom(); t_sg = ~sg;
    got = 0; rdy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy(d)) rdy_hi = 1;
      if (rvld(d)) begin got = 1; break; end
      @(negedge clk);
    end
    r = cyc;
    e = sbq.pop_front();
    chk++;
    if (!got) $display("FAIL %s timeout: no resp_valid within 40 cycles", e.nm);
    else pass_n++;
    chk++;
    if (rdat(d) !== e.rdata) $display("FAIL %s rdata: got %h want %h", e.nm, rdat(d), e.rdata);
    else pass_n++;
    chk++;
    if (rerr(d) !== e.err) $display("FAIL %s err: got %b want %b", e.nm, rerr(d), e.err);
    else pass_n++;
    chk++;
    if (r - n !== e.lat - 1) $display("FAIL %s latency: got N+%0d want N+%0d", e.nm, r - n + 1, e.lat);
    else pass_n++;
    chk++;
    if (rdy_hi !== 1'b0) $display("FAIL %s req_ready: got high while busy want low", e.nm);
    else pass_n++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk++;
    if ({bus0.resp_valid, bus0.resp_err, bus0.mem_we} !== 3'b000)
      $display("FAIL reset_ctl: got %b want 000", {bus0.resp_valid, bus0.resp_err, bus0.mem_we});
    else pass_n++;
    chk++;
    if ({bus0.resp_rdata, bus0.mem_addr, bus0.mem_wdata} !== 96'h0)
      $display("FAIL reset_data: got %h want 0", {bus0.resp_rdata, bus0.mem_addr, bus0.mem_wdata});
    else pass_n++;
    rst_b = 1'b1;
    @(negedge clk);
    chk++;
    if ({bus0.req_ready, bus3.req_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b want 11", {bus0.req_ready, bus3.req_ready});
    else pass_n++;
  endtask

  task automatic test_word();
    int n, r;
    xact(0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, "sw_10", n, r);
    chk++;
    if (rd_word(0, 'h10) !== 32'hDEADBEEF) $display("FAIL sw_mem: got %h want DEADBEEF", rd_word(0, 'h10));
    else pass_n++;
    xact(0, 0, SZ_W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, "lw_10", n, r);
  endtask

  task automatic test_subword();
    int n, r;
    pre_word(0, 'h20, 32'h11223344);
    xact(0, 1, SZ_B, 0, 32'h22, 32'h123456AA, 32'h0, 0, 3, "sb_22", n, r);
    chk++;
    if (rd_word(0, 'h20) !== 32'h1122AA44) $display("FAIL sb_mem: got %h want 1122AA44", rd_word(0, 'h20));
    else pass_n++;
    xact(0, 0, SZ_B, 1, 32'h22, 32'h0, 32'hFFFFFFAA, 0, 2, "lb_22", n, r);
    xact(0, 0, SZ_B, 0, 32'h22, 32'h0, 32'h000000AA, 0, 2, "lbu_22", n, r);
    xact(0, 0, SZ_B, 1, 32'h20, 32'h0, 32'h00000011, 0, 2, "lb_20_pos", n, r);
    pre_word(0, 'h20, 32'h11223344);
    xact(0, 1, SZ_H, 0, 32'h22, 32'hFFFF8001, 32'h0, 0, 3, "sh_22", n, r);
    chk++;
    if (rd_word(0, 'h20) !== 32'h11228001) $display("FAIL sh_mem: got %h want 11228001", rd_word(0, 'h20));
    else pass_n++;
    xact(0, 0, SZ_H, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 2, "lh_22", n, r);
    xact(0, 0, SZ_H, 0, 32'h20, 32'h0, 32'h00001122, 0, 2, "lhu_20", n, r);
    xact(0, 1, SZ_B, 0, 32'h23, 32'h0000005A, 32'h0, 0, 3, "sb_23", n, r);
    chk++;
    if (rd_word(0, 'h20) !== 32'h1122805A) $display("FAIL sb23_mem: got %h want 1122805A", rd_word(0, 'h20));
    else pass_n++;
  endtask

  task automatic test_errors();
    int n, r, we_before;
    pre_word(0, 'h20, 32'h11223344);
    we_before = we0_cnt;
    xact(0, 0, SZ_W, 0, 32'h21, 32'h0, 32'h0, 1, 1, "lw_misal", n, r);
    xact(0, 1, SZ_H, 0, 32'h23, 32'h5555, 32'h0, 1, 1, "sh_misal", n, r);
    xact(0, 1, 2'b11, 0, 32'h20, 32'h77777777, 32'h0, 1, 1, "size_11", n, r);
    xact(0, 0, SZ_W, 0, 32'h10000, 32'h0, 32'h0, 1, 1, "lw_range", n, r);
    xact(0, 1, SZ_H, 0, 32'hFFFFFFFE, 32'h1234, 32'h0, 1, 1, "sh_wrap", n, r);
    @(negedge clk);
    chk++;
    if (we0_cnt - we_before !== 0) $display("FAIL err_mem_we: got %0d write cycles want 0", we0_cnt - we_before);
    else pass_n++;
    chk++;
    if (rd_word(0, 'h20) !== 32'h11223344) $display("FAIL err_mem: got %h want 11223344", rd_word(0, 'h20));
    else pass_n++;
    xact(0, 1, SZ_W, 0, 32'hFFFC, 32'h12345678, 32'h0, 0, 2, "sw_top", n, r);
    chk++;
    if (rd_word(0, 'hFC) !== 32'h12345678) $display("FAIL sw_top_mem: got %h want 12345678", rd_word(0, 'hFC));
    else pass_n++;
    xact(0, 1, SZ_H, 0, 32'hFFFE, 32'h0000BEEF, 32'h0, 0, 3, "sh_top", n, r);
    chk++;
    if (rd_word(0, 'hFC) !== 32'h1234BEEF) $display("FAIL sh_top_mem: got %h want 1234BEEF", rd_word(0, 'hFC));
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    int n1, r1, n2, r2;
    xact(0, 1, SZ_W, 0, 32'h50, 32'hAABBCCDD, 32'h0, 0, 2, "b2b_sw", n1, r1);
    xact(0, 0, SZ_W, 0, 32'h50, 32'h0, 32'hAABBCCDD, 0, 2, "b2b_lw", n2, r2);
    chk++;
    if (n2 - r1 !== 2) $display("FAIL b2b_gap: got accept %0d cycles after resp want 1", n2 - r1 - 1);
    else pass_n++;
  endtask

  task automatic test_wait3();
    int n, r, wc;
    pre_word(3, 'h40, 32'h11223344);
    xact(3, 0, SZ_W, 0, 32'h40, 32'h0, 32'h11223344, 0, 5, "w3_lw", n, r);
    wc = we3_cnt;
    xact(3, 1, SZ_B, 0, 32'h41, 32'h000000AA, 32'h0, 0, 6, "w3_sb", n, r);
    chk++;
    if (we3_cnt - wc !== 1 || we3_last !== n + 4)
      $display("FAIL w3_we: got %0d cycles last N+%0d want 1 cycle at N+5", we3_cnt - wc, we3_last - n + 1);
    else pass_n++;
    chk++;
    if (rd_word(3, 'h40) !== 32'h11AA3344) $display("FAIL w3_mem: got %h want 11AA3344", rd_word(3, 'h40));
    else pass_n++;
  endtask

  task automatic test_reset_mid_wr();
    int rvc;
    pre_word(0, 'h30, 32'h11223344);
    rvc = rv0_cnt;
    @(negedge clk);
    t_we = 1'b1; t_size = SZ_B; t_sg = 1'b0; t_addr = 32'h31; t_wdata = 32'h000000AA;
    rv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv0 = 1'b0;
    @(negedge clk);
    chk++;
    if (bus0.mem_we !== 1'b1) $display("FAIL rst_wr_entry: got mem_we %b want 1", bus0.mem_we);
    else pass_n++;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk++;
    if (bus0.req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus0.req_ready);
    else pass_n++;
    chk++;
    if (rv0_cnt - rvc !== 0) $display("FAIL rst_resp: got %0d responses want 0", rv0_cnt - rvc);
    else pass_n++;
    chk++;
    if (rd_word(0, 'h30) !== 32'h11223344) $display("FAIL rst_mem: got %h want 11223344", rd_word(0, 'h30));
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back();
    test_wait3();
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", pass_n, chk);
    $finish;
  end
endmodule
